// File: rtl/unified_cache_mem_ctrl.sv
// Memory-side controller behind unified_cache: queues to_mem requests in order,
// services them against a block-granular backing store, returns fills on from_mem.
`timescale 1ns/1ps

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_DATA_POS_LO    0
`define UNIFIED_CACHE_PACKET_DATA_POS_HI    31
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO    32
`define UNIFIED_CACHE_PACKET_ADDR_POS_HI    63
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS   64
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO    65
`define UNIFIED_CACHE_PACKET_PORT_NUM_HI    66
`define UNIFIED_CACHE_PACKET_VALID_POS      67
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  68
`endif

// state   | meaning
// IDLE    | waiting for a queued request; pops the queue head when one exists
// BUSY    | access latency countdown for the request in the working register
// RESPOND | fill packet presented on from_mem, held until the cache acks it
module unified_cache_mem_ctrl #(
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
    parameter int BLOCK_SIZE_IN_BYTES                = 4,
    parameter int NUM_BLOCKS                         = 256,
    parameter int MEM_LATENCY                        = 4,
    parameter int REQ_QUEUE_SIZE                     = 4
) (
    input  logic                                          clk_in,
    input  logic                                          reset_in,
    input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] to_mem_packet_in,
    output logic                                          to_mem_packet_ack_out,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] from_mem_packet_out,
    input  logic                                          from_mem_packet_ack_in,
    output logic                                          busy_out
);

    localparam int PW    = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int DW    = BLOCK_SIZE_IN_BYTES * 8;
    localparam int OFF_W = $clog2(BLOCK_SIZE_IN_BYTES);
    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int PTR_W = $clog2(REQ_QUEUE_SIZE);
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam int BLK_LO = `UNIFIED_CACHE_PACKET_ADDR_POS_LO + OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    logic [PW-1:0]    r_fifo [REQ_QUEUE_SIZE];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_ack;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_work;
    logic [PW-1:0]    r_resp;

    logic [DW-1:0]    r_store [NUM_BLOCKS];

    logic             w_full;
    logic             w_accept;
    logic             w_pop;
    logic             w_done;
    logic             w_store_wr;
    logic [IDX_W-1:0] w_idx;
    logic [DW-1:0]    w_rd_data;
    logic [PW-1:0]    w_resp;

    assign w_full     = (r_count == (PTR_W+1)'(REQ_QUEUE_SIZE));
    // r_ack blocks a second accept of the packet the arbiter still holds after our ack.
    assign w_accept   = to_mem_packet_in[`UNIFIED_CACHE_PACKET_VALID_POS] && !w_full && !r_ack;
    assign w_pop      = (r_state == ST_IDLE) && (r_count != '0);
    assign w_done     = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_store_wr = w_done && r_work[`UNIFIED_CACHE_PACKET_IS_WRITE_POS];
    assign w_idx      = r_work[BLK_LO +: IDX_W];
    assign w_rd_data  = r_store[w_idx];

    // Fill packet: request header copied through; accepted requests always carry valid=1.
    always_comb begin
        w_resp = r_work;
        w_resp[`UNIFIED_CACHE_PACKET_IS_WRITE_POS] = 1'b0;
        w_resp[`UNIFIED_CACHE_PACKET_DATA_POS_HI:`UNIFIED_CACHE_PACKET_DATA_POS_LO] = w_rd_data;
        w_resp[`UNIFIED_CACHE_PACKET_VALID_POS] = r_work[`UNIFIED_CACHE_PACKET_VALID_POS];
    end

    // Backing store and queue storage survive reset; only control state is cleared.
    always_ff @(posedge clk_in) begin
        if (w_store_wr) begin
            r_store[w_idx] <= r_work[`UNIFIED_CACHE_PACKET_DATA_POS_HI:`UNIFIED_CACHE_PACKET_DATA_POS_LO];
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= to_mem_packet_in;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= w_accept;
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_resp  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_work  <= r_fifo[r_rd_ptr];
                        r_cnt   <= CNT_W'(MEM_LATENCY - 1);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        if (r_work[`UNIFIED_CACHE_PACKET_IS_WRITE_POS]) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_resp  <= w_resp;
                            r_state <= ST_RESPOND;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESPOND: begin
                    if (from_mem_packet_ack_in) begin
                        r_resp  <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign to_mem_packet_ack_out = r_ack;
    assign from_mem_packet_out   = r_resp;
    assign busy_out              = (r_count != '0) || (r_state != ST_IDLE);

endmodule

// File: tb/tb_unified_cache_mem_ctrl.sv
// Scoreboard bench for unified_cache_mem_ctrl: directed scenarios plus a randomized
// run, checked against a flat block-array model of the backing store.
`timescale 1ns/1ps

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_DATA_POS_LO    0
`define UNIFIED_CACHE_PACKET_DATA_POS_HI    31
`define UNIFIED_CACHE_PACKET_ADDR_POS_LO    32
`define UNIFIED_CACHE_PACKET_ADDR_POS_HI    63
`define UNIFIED_CACHE_PACKET_IS_WRITE_POS   64
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO    65
`define UNIFIED_CACHE_PACKET_PORT_NUM_HI    66
`define UNIFIED_CACHE_PACKET_VALID_POS      67
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS  68
`endif

module tb_unified_cache_mem_ctrl;

    localparam int PW     = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int NBLK   = 256;
    localparam int BSIZE  = 4;
    localparam int LAT    = 4;
    localparam int VPOS   = `UNIFIED_CACHE_PACKET_VALID_POS;

    logic          clk_in = 1'b0;
    logic          reset_in = 1'b0;
    logic [PW-1:0] to_mem_packet_in = '0;
    logic          to_mem_packet_ack_out;
    logic [PW-1:0] from_mem_packet_out;
    logic          from_mem_packet_ack_in = 1'b0;
    logic          busy_out;

    unified_cache_mem_ctrl #(
        .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(PW),
        .BLOCK_SIZE_IN_BYTES(BSIZE),
        .NUM_BLOCKS(NBLK),
        .MEM_LATENCY(LAT),
        .REQ_QUEUE_SIZE(4)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .to_mem_packet_in(to_mem_packet_in),
        .to_mem_packet_ack_out(to_mem_packet_ack_out),
        .from_mem_packet_out(from_mem_packet_out),
        .from_mem_packet_ack_in(from_mem_packet_ack_in),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [PW-1:0] pkt;
        int            exp_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] model [NBLK];
    int          last_acc;

    bit ack_hold = 1'b0;
    bit rand_ack = 1'b0;
    int ack_wait = 0;
    bit prev_v = 1'b0;
    int first_cyc = 0;

    function automatic logic [PW-1:0] mk(input logic [31:0] addr, input bit wr,
                                         input logic [1:0] port, input logic [31:0] data);
        logic [PW-1:0] p;
        p = '0;
        p[`UNIFIED_CACHE_PACKET_ADDR_POS_HI:`UNIFIED_CACHE_PACKET_ADDR_POS_LO] = addr;
        p[`UNIFIED_CACHE_PACKET_DATA_POS_HI:`UNIFIED_CACHE_PACKET_DATA_POS_LO] = data;
        p[`UNIFIED_CACHE_PACKET_PORT_NUM_HI:`UNIFIED_CACHE_PACKET_PORT_NUM_LO] = port;
        p[`UNIFIED_CACHE_PACKET_IS_WRITE_POS] = wr;
        p[VPOS] = 1'b1;
        return p;
    endfunction

    function automatic int blk(input logic [31:0] addr);
        return int'((addr / BSIZE) % NBLK);
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: on every presented fill, pop the scoreboard and ack (optionally after a delay).
    always @(negedge clk_in) begin
        if (!reset_in) begin
            from_mem_packet_ack_in = 1'b0;
            prev_v = 1'b0;
        end else if (from_mem_packet_out[VPOS]) begin
            if (!prev_v) begin
                first_cyc = cyc;
                ack_wait = rand_ack ? int'($urandom_range(0, 3)) : 0;
            end
            prev_v = 1'b1;
            if (ack_hold || ack_wait > 0) begin
                if (!ack_hold) ack_wait--;
                from_mem_packet_ack_in = 1'b0;
            end else begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp @cyc %0d: got %h expected none", cyc, from_mem_packet_out);
                end else begin
                    e = sb.pop_front();
                    chk("resp_pkt", from_mem_packet_out, e.pkt);
                    if (e.exp_cyc >= 0) chk_int("resp_latency", first_cyc, e.exp_cyc);
                end
                from_mem_packet_ack_in = 1'b1;
                prev_v = 1'b0;
            end
        end else begin
            prev_v = 1'b0;
            from_mem_packet_ack_in = rand_ack && ($urandom_range(0, 3) == 0);
        end
    end

    // Called at #1 after a rising edge; holds the packet like the arbiter does until acked.
    task automatic send(input logic [31:0] addr, input bit wr, input logic [1:0] port,
                        input logic [31:0] data, input bit track, input bit lat,
                        input int budget, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        to_mem_packet_in = mk(addr, wr, port, data);
        while (!to_mem_packet_ack_out && n < budget) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (to_mem_packet_ack_out) begin
            ok = 1'b1;
            last_acc = cyc - 1;
            if (track) begin
                if (wr) model[blk(addr)] = data;
                else sb.push_back('{mk(addr, 1'b0, port, model[blk(addr)]),
                                    lat ? last_acc + LAT + 2 : -1});
            end
            @(posedge clk_in); #1;
            chk_int("ack_single_pulse", int'(to_mem_packet_ack_out), 0);
            to_mem_packet_in = '0;
        end
    endtask

    task automatic req(input logic [31:0] addr, input bit wr, input logic [1:0] port,
                       input logic [31:0] data, input bit track, input bit lat);
        bit ok;
        send(addr, wr, port, data, track, lat, 40, ok);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout @cyc %0d: got no ack expected ack for addr %h", cyc, addr);
            to_mem_packet_in = '0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_out || sb.size() != 0) && n < budget) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout @cyc %0d: got busy expected idle", cyc);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!from_mem_packet_out[VPOS] && n < budget) begin
            @(posedge clk_in); #1;
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL valid_timeout @cyc %0d: got no response expected response", cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog @cyc %0d: got hang expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        logic [31:0] a;

        repeat (2) @(posedge clk_in);
        #1;
        chk("reset_from_mem", from_mem_packet_out, '0);
        chk_int("reset_ack", int'(to_mem_packet_ack_out), 0);
        chk_int("reset_busy", int'(busy_out), 0);
        reset_in = 1'b1;
        @(posedge clk_in); #1;

        // 1: write then read, latency and header copy
        req(32'h40, 1'b1, 2'd0, 32'hDEADBEEF, 1'b1, 1'b0);
        wait_idle(40);
        chk_int("wr_done_cycle", cyc, last_acc + LAT + 2);
        req(32'h40, 1'b0, 2'd1, 32'h0, 1'b1, 1'b1);
        wait_idle(40);

        // 2: held response stays stable, next queued request starts only after ack
        req(32'h80, 1'b1, 2'd0, 32'h12345678, 1'b1, 1'b0);
        wait_idle(40);
        ack_hold = 1'b1;
        req(32'h40, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0);
        req(32'h80, 1'b0, 2'd3, 32'h0, 1'b1, 1'b0);
        wait_valid(40);
        for (int i = 0; i < 10; i++) begin
            chk("hold_stable", from_mem_packet_out, mk(32'h40, 1'b0, 2'd2, 32'hDEADBEEF));
            @(posedge clk_in); #1;
        end
        ack_hold = 1'b0;
        @(posedge clk_in); #1;
        chk("clear_after_ack", from_mem_packet_out, '0);
        n = 0;
        while (!from_mem_packet_out[VPOS] && n < 20) begin
            @(posedge clk_in); #1;
            n++;
        end
        chk_int("next_resp_gap", n, LAT + 1);
        wait_idle(40);

        // 3: queue fills while stalled in RESPOND
        ack_hold = 1'b1;
        req(32'h40, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
        wait_valid(40);
        for (int k = 0; k < 4; k++) req(32'h100 + 4 * k, 1'b1, 2'd0, 32'hA000 + k, 1'b1, 1'b0);
        send(32'h110, 1'b1, 2'd0, 32'hA004, 1'b1, 1'b0, 12, ok);
        chk_int("no_ack_when_full", int'(ok), 0);
        ack_hold = 1'b0;
        send(32'h110, 1'b1, 2'd0, 32'hA004, 1'b1, 1'b0, 40, ok);
        chk_int("ack_after_drain", int'(ok), 1);
        req(32'h114, 1'b1, 2'd0, 32'hA005, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) req(32'h100 + 4 * k, 1'b0, 2'(k), 32'h0, 1'b1, 1'b0);
        wait_idle(100);

        // 4: write-after-write then read, back to back
        req(32'h0C, 1'b1, 2'd0, 32'h11, 1'b1, 1'b0);
        req(32'h0C, 1'b1, 2'd0, 32'h22, 1'b1, 1'b0);
        req(32'h0C, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0);
        wait_idle(60);

        // 5: aliasing across NUM_BLOCKS
        req(32'h400, 1'b1, 2'd0, 32'h5A, 1'b1, 1'b0);
        req(32'h000, 1'b0, 2'd1, 32'h0, 1'b1, 1'b0);
        wait_idle(60);

        // 6: reset mid-BUSY with three requests queued
        req(32'h28, 1'b1, 2'd0, 32'hCAFE0010, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) req(32'h50 + 4 * k, 1'b1, 2'd0, 32'hB0 + k, 1'b1, 1'b0);
        wait_idle(80);
        ack_hold = 1'b1;
        req(32'h28, 1'b0, 2'd1, 32'h0, 1'b1, 1'b0);
        wait_valid(40);
        for (int k = 0; k < 4; k++) req(32'h50 + 4 * k, 1'b1, 2'd0, 32'hEE00 + k, 1'b0, 1'b0);
        ack_hold = 1'b0;
        repeat (3) begin
            @(posedge clk_in); #1;
        end
        chk_int("busy_before_reset", int'(busy_out), 1);
        reset_in = 1'b0;
        #1;
        chk("rst_from_mem", from_mem_packet_out, '0);
        chk_int("rst_ack", int'(to_mem_packet_ack_out), 0);
        chk_int("rst_busy", int'(busy_out), 0);
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 1'b1;
        repeat (8) begin
            @(posedge clk_in); #1;
        end
        chk_int("post_reset_busy", int'(busy_out), 0);
        req(32'h28, 1'b0, 2'd1, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) req(32'h50 + 4 * k, 1'b0, 2'd2, 32'h0, 1'b1, 1'b0);
        wait_idle(100);

        // Randomized mix over 16 blocks with aliased addresses and random ack delays
        for (int b = 0; b < 16; b++) req(32'(b * 4), 1'b1, 2'd0, $urandom, 1'b1, 1'b0);
        wait_idle(200);
        rand_ack = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = 32'(($urandom_range(0, 7) * NBLK + $urandom_range(0, 15)) * BSIZE
                    + $urandom_range(0, 3));
            req(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1'b1, 1'b0);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 6)) @(posedge clk_in);
                #1;
            end
        end
        wait_idle(400);
        rand_ack = 1'b0;
        chk_int("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
